// File: rtl/regfile_pkg.sv
// Shared register-file constants used by the operand-fetch stage and its lanes.
package regfile_pkg;

    localparam int REGFILE_WIDTH      = 32;
    localparam int REGFILE_DEPTH_LOG2 = 4;
    localparam int OPFETCH_TAG_W      = 8;

    // Architectural zero register: always reads as 0 and is never a forwarding target.
    localparam int ZERO_REG = 0;

endpackage

// File: rtl/regfile_operand_fetch_if.sv
// Bundle of the issue, regfile-read, writeback and operand-out signals of the operand-fetch stage.
interface regfile_operand_fetch_if #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4,
    parameter int TAG_W      = 8
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1; a producer
    // holds valid and its payload stable until that edge, and ready never depends on valid.
    logic                  in_valid;
    logic                  in_ready;
    logic [DEPTH_LOG2-1:0] in_rs1_addr;
    logic [DEPTH_LOG2-1:0] in_rs2_addr;
    logic [DEPTH_LOG2-1:0] in_rd_addr;
    logic [TAG_W-1:0]      in_tag;

    logic                  rs1_read;
    logic [DEPTH_LOG2-1:0] rs1_addr;
    logic [WIDTH-1:0]      rs1_rdata;
    logic                  rs2_read;
    logic [DEPTH_LOG2-1:0] rs2_addr;
    logic [WIDTH-1:0]      rs2_rdata;

    logic                  wb_write;
    logic [DEPTH_LOG2-1:0] wb_addr;
    logic [WIDTH-1:0]      wb_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_rs1_data;
    logic [WIDTH-1:0]      out_rs2_data;
    logic [DEPTH_LOG2-1:0] out_rd_addr;
    logic [TAG_W-1:0]      out_tag;

    modport slave (
        input  in_valid, in_rs1_addr, in_rs2_addr, in_rd_addr, in_tag,
        output in_ready,
        output rs1_read, rs1_addr, rs2_read, rs2_addr,
        input  rs1_rdata, rs2_rdata,
        input  wb_write, wb_addr, wb_data,
        output out_valid, out_rs1_data, out_rs2_data, out_rd_addr, out_tag,
        input  out_ready
    );

    modport master (
        output in_valid, in_rs1_addr, in_rs2_addr, in_rd_addr, in_tag,
        input  in_ready,
        input  rs1_read, rs1_addr, rs2_read, rs2_addr,
        output rs1_rdata, rs2_rdata,
        output wb_write, wb_addr, wb_data,
        input  out_valid, out_rs1_data, out_rs2_data, out_rd_addr, out_tag,
        output out_ready
    );

endinterface

// File: rtl/regfile_operand_fetch_lane.sv
// One source-operand lane: writeback forwarding around the read-before-write regfile,
// zero-register forcing, and in-place update of a held output operand.
module opfetch_lane
    import regfile_pkg::*;
#(
    parameter int WIDTH      = REGFILE_WIDTH,
    parameter int DEPTH_LOG2 = REGFILE_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_i,
    input  logic [DEPTH_LOG2-1:0] issue_addr_i,
    input  logic                  rd_adv_i,
    input  logic [DEPTH_LOG2-1:0] rd_src_i,
    input  logic                  out_hold_i,
    input  logic                  wb_write_i,
    input  logic [DEPTH_LOG2-1:0] wb_addr_i,
    input  logic [WIDTH-1:0]      wb_data_i,
    input  logic [WIDTH-1:0]      rdata_i,
    output logic [WIDTH-1:0]      operand_o
);

    localparam logic [DEPTH_LOG2-1:0] ZERO_ADDR = DEPTH_LOG2'(ZERO_REG);

    logic                  fwd_q,      fwd_d;
    logic [WIDTH-1:0]      fwd_data_q, fwd_data_d;
    logic [DEPTH_LOG2-1:0] out_src_q,  out_src_d;
    logic [WIDTH-1:0]      operand_q,  operand_d;

    always_comb begin
        fwd_d      = fwd_q;
        fwd_data_d = fwd_data_q;
        out_src_d  = out_src_q;
        operand_d  = operand_q;
        // The regfile returns the pre-write value, so a same-cycle write must be captured here.
        if (issue_i) begin
            fwd_d = wb_write_i && (wb_addr_i == issue_addr_i) && (issue_addr_i != ZERO_ADDR);
            if (fwd_d) fwd_data_d = wb_data_i;
        end
        if (rd_adv_i) begin
            out_src_d = rd_src_i;
            if (rd_src_i == ZERO_ADDR) operand_d = '0;
            else if (fwd_q)            operand_d = fwd_data_q;
            else                       operand_d = rdata_i;
        end else if (out_hold_i && wb_write_i && (wb_addr_i == out_src_q) &&
                     (out_src_q != ZERO_ADDR)) begin
            operand_d = wb_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
            out_src_q  <= '0;
            operand_q  <= '0;
        end else begin
            fwd_q      <= fwd_d;
            fwd_data_q <= fwd_data_d;
            out_src_q  <= out_src_d;
            operand_q  <= operand_d;
        end
    end

    assign operand_o = operand_q;

endmodule

// File: rtl/regfile_operand_fetch.sv
// Two-stage operand fetch (RD: read outstanding, OUT: registered bundle) in front of regfile_2r1w.
module regfile_operand_fetch
    import regfile_pkg::*;
#(
    parameter int WIDTH      = REGFILE_WIDTH,
    parameter int DEPTH_LOG2 = REGFILE_DEPTH_LOG2,
    parameter int TAG_W      = OPFETCH_TAG_W
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_operand_fetch_if.slave  bus
);

    logic                  rd_valid_q, rd_valid_d;
    logic [DEPTH_LOG2-1:0] rd_rs1_q,   rd_rs1_d;
    logic [DEPTH_LOG2-1:0] rd_rs2_q,   rd_rs2_d;
    logic [DEPTH_LOG2-1:0] rd_rd_q,    rd_rd_d;
    logic [TAG_W-1:0]      rd_tag_q,   rd_tag_d;
    logic                  out_valid_q, out_valid_d;
    logic [DEPTH_LOG2-1:0] out_rd_q,   out_rd_d;
    logic [TAG_W-1:0]      out_tag_q,  out_tag_d;

    logic out_adv, rd_adv, rd_stall, out_hold, accept, issue;

    assign out_adv  = !out_valid_q || bus.out_ready;
    assign rd_adv   = rd_valid_q && out_adv;
    assign rd_stall = rd_valid_q && !out_adv;
    assign out_hold = out_valid_q && !bus.out_ready;
    assign accept   = bus.in_valid && bus.in_ready;
    // A stalled RD op keeps re-reading so its data follows regfile updates until it can move.
    assign issue    = !rst && (accept || rd_stall);

    assign bus.in_ready = !rd_valid_q || out_adv;
    assign bus.rs1_read = issue;
    assign bus.rs2_read = issue;
    assign bus.rs1_addr = rd_stall ? rd_rs1_q : bus.in_rs1_addr;
    assign bus.rs2_addr = rd_stall ? rd_rs2_q : bus.in_rs2_addr;

    always_comb begin
        rd_valid_d  = rd_valid_q;
        rd_rs1_d    = rd_rs1_q;
        rd_rs2_d    = rd_rs2_q;
        rd_rd_d     = rd_rd_q;
        rd_tag_d    = rd_tag_q;
        out_rd_d    = out_rd_q;
        out_tag_d   = out_tag_q;
        out_valid_d = rd_adv || out_hold;
        if (accept) begin
            rd_valid_d = 1'b1;
            rd_rs1_d   = bus.in_rs1_addr;
            rd_rs2_d   = bus.in_rs2_addr;
            rd_rd_d    = bus.in_rd_addr;
            rd_tag_d   = bus.in_tag;
        end else if (rd_adv) begin
            rd_valid_d = 1'b0;
        end
        if (rd_adv) begin
            out_rd_d  = rd_rd_q;
            out_tag_d = rd_tag_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q  <= 1'b0;
            rd_rs1_q    <= '0;
            rd_rs2_q    <= '0;
            rd_rd_q     <= '0;
            rd_tag_q    <= '0;
            out_valid_q <= 1'b0;
            out_rd_q    <= '0;
            out_tag_q   <= '0;
        end else begin
            rd_valid_q  <= rd_valid_d;
            rd_rs1_q    <= rd_rs1_d;
            rd_rs2_q    <= rd_rs2_d;
            rd_rd_q     <= rd_rd_d;
            rd_tag_q    <= rd_tag_d;
            out_valid_q <= out_valid_d;
            out_rd_q    <= out_rd_d;
            out_tag_q   <= out_tag_d;
        end
    end

    opfetch_lane #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_lane_rs1 (
        .clk(clk), .rst(rst), .issue_i(issue), .issue_addr_i(bus.rs1_addr),
        .rd_adv_i(rd_adv), .rd_src_i(rd_rs1_q), .out_hold_i(out_hold),
        .wb_write_i(bus.wb_write), .wb_addr_i(bus.wb_addr), .wb_data_i(bus.wb_data),
        .rdata_i(bus.rs1_rdata), .operand_o(bus.out_rs1_data)
    );

    opfetch_lane #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_lane_rs2 (
        .clk(clk), .rst(rst), .issue_i(issue), .issue_addr_i(bus.rs2_addr),
        .rd_adv_i(rd_adv), .rd_src_i(rd_rs2_q), .out_hold_i(out_hold),
        .wb_write_i(bus.wb_write), .wb_addr_i(bus.wb_addr), .wb_data_i(bus.wb_data),
        .rdata_i(bus.rs2_rdata), .operand_o(bus.out_rs2_data)
    );

    assign bus.out_valid   = out_valid_q;
    assign bus.out_rd_addr = out_rd_q;
    assign bus.out_tag     = out_tag_q;

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Directed bench for regfile_operand_fetch paired with a read-before-write 2R1W regfile model.
module tb_regfile_operand_fetch;

    localparam int W  = 32;
    localparam int AW = 4;
    localparam int TW = 8;
    localparam int BW = W + W + AW + TW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_operand_fetch_if #(.WIDTH(W), .DEPTH_LOG2(AW), .TAG_W(TW)) bus ();

    regfile_operand_fetch #(.WIDTH(W), .DEPTH_LOG2(AW), .TAG_W(TW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Regfile model: registered read data, write lands after the read samples (read-before-write).
    logic [W-1:0] mem [16];
    logic         mem_init;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            if (bus.rs1_read) bus.rs1_rdata <= mem[bus.rs1_addr];
            if (bus.rs2_read) bus.rs2_rdata <= mem[bus.rs2_addr];
            if (bus.wb_write) mem[bus.wb_addr] <= bus.wb_data;
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [BW-1:0] exp_q [$];
    int pop_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: every bundle the stage hands downstream is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_bundle: got %0h required none",
                         {bus.out_rs1_data, bus.out_rs2_data, bus.out_rd_addr, bus.out_tag});
            end else begin
                check("bundle", {bus.out_rs1_data, bus.out_rs2_data, bus.out_rd_addr, bus.out_tag},
                      exp_q.pop_front());
                pop_cyc.push_back(cyc);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [W-1:0] d);
        bus.wb_write = 1'b1;
        bus.wb_addr  = a;
        bus.wb_data  = d;
        wait_cycles(1);
        bus.wb_write = 1'b0;
    endtask

    task automatic drive_op(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                            input logic [AW-1:0] rd, input logic [TW-1:0] tag,
                            input logic [W-1:0] e1, input logic [W-1:0] e2, output int waits);
        bus.in_valid    = 1'b1;
        bus.in_rs1_addr = rs1;
        bus.in_rs2_addr = rs2;
        bus.in_rd_addr  = rd;
        bus.in_tag      = tag;
        waits = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            if (bus.in_ready) break;
            waits++;
        end
        if (waits == 20) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: got in_ready=0 for 20 cycles required 1");
        end else begin
            exp_q.push_back({e1, e2, rd, tag});
        end
        #1;
        bus.in_valid = 1'b0;
    endtask

    int w;
    int waits_tot;

    initial begin
        rst             = 1'b1;
        mem_init        = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_rs1_addr = 4'd3;
        bus.in_rs2_addr = 4'd3;
        bus.in_rd_addr  = '0;
        bus.in_tag      = '0;
        bus.wb_write    = 1'b0;
        bus.wb_addr     = '0;
        bus.wb_data     = '0;
        bus.out_ready   = 1'b1;

        @(negedge clk);
        check("rst_rs1_read", bus.rs1_read, 0);
        check("rst_rs2_read", bus.rs2_read, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        mem_init     = 1'b0;
        bus.in_valid = 1'b0;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_outputs", {bus.out_rs1_data, bus.out_rs2_data, bus.out_rd_addr, bus.out_tag}, 0);

        write_reg(4'd3, 32'h0000_00A5);
        write_reg(4'd7, 32'h0000_0077);
        write_reg(4'd1, 32'h0000_0011);
        write_reg(4'd2, 32'h0000_0022);
        write_reg(4'd4, 32'h0000_0044);
        write_reg(4'd6, 32'h0000_0066);

        // Basic fetch, rs2 = r0, with the two-cycle latency observed directly.
        drive_op(4'd3, 4'd0, 4'd9, 8'h5A, 32'h0000_00A5, 32'h0, w);
        check("latency_n1", bus.out_valid, 0);
        wait_cycles(1);
        check("latency_n2", bus.out_valid, 1);
        wait_cycles(2);

        // Writeback racing the read of r5 is forwarded.
        bus.wb_write = 1'b1;
        bus.wb_addr  = 4'd5;
        bus.wb_data  = 32'h0000_1234;
        drive_op(4'd5, 4'd3, 4'd1, 8'h21, 32'h0000_1234, 32'h0000_00A5, w);
        bus.wb_write = 1'b0;
        wait_cycles(3);

        // Held bundle picks up a writeback to its rs2 source.
        bus.out_ready = 1'b0;
        drive_op(4'd0, 4'd7, 4'd2, 8'h33, 32'h0, 32'h0000_BEEF, w);
        wait_cycles(2);
        check("hold_valid", bus.out_valid, 1);
        check("hold_before_wb", bus.out_rs2_data, 32'h0000_0077);
        bus.wb_write = 1'b1;
        bus.wb_addr  = 4'd7;
        bus.wb_data  = 32'h0000_BEEF;
        wait_cycles(1);
        bus.wb_write = 1'b0;
        check("hold_after_wb", bus.out_rs2_data, 32'h0000_BEEF);
        check("hold_rs1_zero", bus.out_rs1_data, 32'h0);
        bus.out_ready = 1'b1;
        wait_cycles(3);

        // Writes to r0 are never forwarded and r0 always reads as zero.
        bus.wb_write = 1'b1;
        bus.wb_addr  = 4'd0;
        bus.wb_data  = 32'h0000_FFFF;
        drive_op(4'd0, 4'd3, 4'd4, 8'h44, 32'h0, 32'h0000_00A5, w);
        bus.wb_write = 1'b0;
        wait_cycles(3);
        drive_op(4'd0, 4'd0, 4'd5, 8'h45, 32'h0, 32'h0, w);
        wait_cycles(3);

        // Four back-to-back ops at full rate.
        pop_cyc.delete();
        waits_tot = 0;
        drive_op(4'd1, 4'd2, 4'd1, 8'hA1, 32'h0000_0011, 32'h0000_0022, w); waits_tot += w;
        drive_op(4'd3, 4'd4, 4'd2, 8'hA2, 32'h0000_00A5, 32'h0000_0044, w); waits_tot += w;
        drive_op(4'd5, 4'd6, 4'd3, 8'hA3, 32'h0000_1234, 32'h0000_0066, w); waits_tot += w;
        drive_op(4'd7, 4'd1, 4'd4, 8'hA4, 32'h0000_BEEF, 32'h0000_0011, w); waits_tot += w;
        wait_cycles(4);
        check("b2b_no_stall", waits_tot, 0);
        check("b2b_count", pop_cyc.size(), 4);
        if (pop_cyc.size() == 4) check("b2b_consecutive", pop_cyc[3] - pop_cyc[0], 3);

        // Stalled RD op re-reads and forwards a writeback arriving on its last stalled cycle.
        bus.out_ready = 1'b0;
        drive_op(4'd1, 4'd2, 4'd3, 8'h70, 32'h0000_0011, 32'h0000_0022, w);
        drive_op(4'd9, 4'd0, 4'd4, 8'h71, 32'h0000_0099, 32'h0, w);
        check("stall_in_ready", bus.in_ready, 0);
        check("stall_reread", {bus.rs1_read, bus.rs1_addr}, {1'b1, 4'd9});
        wait_cycles(1);
        bus.wb_write = 1'b1;
        bus.wb_addr  = 4'd9;
        bus.wb_data  = 32'h0000_0099;
        wait_cycles(1);
        bus.wb_write  = 1'b0;
        bus.out_ready = 1'b1;
        wait_cycles(4);

        // Reset with both stages full drops everything.
        bus.out_ready = 1'b0;
        drive_op(4'd1, 4'd2, 4'd5, 8'h60, 32'h0000_0011, 32'h0000_0022, w);
        drive_op(4'd3, 4'd4, 4'd6, 8'h61, 32'h0000_00A5, 32'h0000_0044, w);
        check("full_in_ready", bus.in_ready, 0);
        rst = 1'b1;
        #1;
        check("mid_rst_read", {bus.rs1_read, bus.rs2_read}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        check("post_rst_valid", bus.out_valid, 0);
        check("post_rst_outputs", {bus.out_rs1_data, bus.out_rs2_data, bus.out_rd_addr, bus.out_tag}, 0);
        check("post_rst_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        wait_cycles(3);
        check("post_rst_idle", bus.out_valid, 0);
        drive_op(4'd5, 4'd6, 4'd7, 8'h62, 32'h0000_1234, 32'h0000_0066, w);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) wait_cycles(1);
        check("drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
